// File: rtl/logic_latch_bank.sv
// Bank of CHANNELS WIDTH-bit storage channels that emulate 74HC373 transparent
// latches (MODE 0) or 74HC374 edge registers (MODE 1), fully synchronous to CLK.
module logic_latch_bank #(
   parameter int WIDTH       = 8,
   parameter int CHANNELS    = 2,
   parameter int MODE        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [CHANNELS*WIDTH-1:0] D,
   input  logic [CHANNELS-1:0]       LE,
   input  logic [CHANNELS-1:0]       nOE,
   output logic [CHANNELS*WIDTH-1:0] Q,
   output logic [CHANNELS-1:0]       QEN,
   output logic [CHANNELS*WIDTH-1:0] Q_INT,
   output logic [CHANNELS-1:0]       CAP_STB
);

   localparam int DW = CHANNELS * WIDTH;

   logic [DW-1:0]       d_s;
   logic [CHANNELS-1:0] le_s;
   logic [CHANNELS-1:0] noe_s;

   // D, LE and nOE share one chain depth so a pin change keeps its alignment.
   if (SYNC_STAGES == 0) begin : g_no_sync
      assign d_s   = D;
      assign le_s  = LE;
      assign noe_s = nOE;
   end else begin : g_sync
      logic [DW-1:0]       d_q   [SYNC_STAGES];
      logic [CHANNELS-1:0] le_q  [SYNC_STAGES];
      logic [CHANNELS-1:0] noe_q [SYNC_STAGES];

      // NOTE: nOE stages reset to all 1s so outputs come out of reset disabled.
      always_ff @(posedge CLK) begin
         if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
               d_q[i]   <= '0;
               le_q[i]  <= '0;
               noe_q[i] <= '1;
            end
         end else begin
            d_q[0]   <= D;
            le_q[0]  <= LE;
            noe_q[0] <= nOE;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               d_q[i]   <= d_q[i-1];
               le_q[i]  <= le_q[i-1];
               noe_q[i] <= noe_q[i-1];
            end
         end
      end

      assign d_s   = d_q[SYNC_STAGES-1];
      assign le_s  = le_q[SYNC_STAGES-1];
      assign noe_s = noe_q[SYNC_STAGES-1];
   end

   logic [DW-1:0]       st_q, st_d;
   logic [CHANNELS-1:0] le_p_q;
   logic [CHANNELS-1:0] stb_q, stb_d;

   always_comb begin
      st_d  = st_q;
      stb_d = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (MODE == 0) begin
            if (le_s[c]) st_d[c*WIDTH +: WIDTH] = d_s[c*WIDTH +: WIDTH];
         end else begin
            if (le_s[c] && !le_p_q[c]) begin
               st_d[c*WIDTH +: WIDTH] = d_s[c*WIDTH +: WIDTH];
               stb_d[c]               = 1'b1;
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         st_q   <= '0;
         le_p_q <= '0;
         stb_q  <= '0;
      end else begin
         st_q   <= st_d;
         le_p_q <= le_s;
         stb_q  <= stb_d;
      end
   end

   always_comb begin
      Q = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         Q[c*WIDTH +: WIDTH] = noe_s[c] ? '0 : st_q[c*WIDTH +: WIDTH];
      end
   end

   // Latch mode strobes on the falling latch enable; edge mode on the registered capture.
   assign CAP_STB = (MODE == 0) ? (~le_s & le_p_q) : stb_q;
   assign QEN     = ~noe_s;
   assign Q_INT   = st_q;

endmodule

// File: tb/tb_logic_latch_bank.sv
// Bench for logic_latch_bank: a MODE 0 and a MODE 1 instance (4 x 8 bits, 2 sync
// stages) checked every cycle against a pin-history model plus directed literals.
module tb_logic_latch_bank;

   localparam int W = 8;
   localparam int C = 4;
   localparam int S = 2;

   typedef struct packed {
      logic [C*W-1:0] d;
      logic [C-1:0]   le;
      logic [C-1:0]   noe;
   } pins_t;

   logic clk = 1'b0;
   logic rst;
   logic [C*W-1:0] d0, d1;
   logic [C-1:0]   le0, le1, noe0, noe1;

   logic [C*W-1:0] q_o    [2];
   logic [C*W-1:0] qint_o [2];
   logic [C-1:0]   qen_o  [2];
   logic [C-1:0]   cap_o  [2];

   int total = 0;
   int bad   = 0;

   initial forever #5 clk = ~clk;

   logic_latch_bank #(.WIDTH(W), .CHANNELS(C), .MODE(0), .SYNC_STAGES(S)) u_m0 (
      .CLK(clk), .RST(rst), .D(d0), .LE(le0), .nOE(noe0),
      .Q(q_o[0]), .QEN(qen_o[0]), .Q_INT(qint_o[0]), .CAP_STB(cap_o[0])
   );

   logic_latch_bank #(.WIDTH(W), .CHANNELS(C), .MODE(1), .SYNC_STAGES(S)) u_m1 (
      .CLK(clk), .RST(rst), .D(d1), .LE(le1), .nOE(noe1),
      .Q(q_o[1]), .QEN(qen_o[1]), .Q_INT(qint_o[1]), .CAP_STB(cap_o[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Model: the pins seen at each edge since reset; the synchronised view is
   // simply the entry S edges back, reset defaults before that.
   pins_t     hist0[$];
   pins_t     hist1[$];
   logic [W-1:0] m_st  [2][C];
   logic [C-1:0] m_stb [2];
   bit           model_ok = 0;

   function automatic pins_t view(input int inst, input int back);
      pins_t p;
      int    idx;
      p   = '{d: '0, le: '0, noe: '1};
      idx = ((inst == 0) ? hist0.size() : hist1.size()) - S - back;
      if (idx >= 0) p = (inst == 0) ? hist0[idx] : hist1[idx];
      return p;
   endfunction

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_stb[i] = '0;
         for (int c = 0; c < C; c++) m_st[i][c] = '0;
      end
      forever begin
         @(posedge clk);
         if (rst) begin
            hist0.delete();
            hist1.delete();
            for (int i = 0; i < 2; i++) begin
               m_stb[i] = '0;
               for (int c = 0; c < C; c++) m_st[i][c] = '0;
            end
            model_ok = 1;
         end else begin
            for (int i = 0; i < 2; i++) begin
               pins_t v, vp;
               v  = view(i, 0);
               vp = view(i, 1);
               m_stb[i] = '0;
               for (int c = 0; c < C; c++) begin
                  if (i == 0) begin
                     if (v.le[c]) m_st[i][c] = v.d[c*W +: W];
                  end else if (v.le[c] && !vp.le[c]) begin
                     m_st[i][c]  = v.d[c*W +: W];
                     m_stb[i][c] = 1'b1;
                  end
               end
            end
            hist0.push_back('{d: d0, le: le0, noe: noe0});
            hist1.push_back('{d: d1, le: le1, noe: noe1});
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (model_ok) begin
         for (int i = 0; i < 2; i++) begin
            pins_t        v, vp;
            logic [31:0]  e_q, e_qint;
            logic [C-1:0] e_cap;
            v  = view(i, 0);
            vp = view(i, 1);
            e_q    = '0;
            e_qint = '0;
            for (int c = 0; c < C; c++) begin
               e_qint[c*W +: W] = m_st[i][c];
               if (!v.noe[c]) e_q[c*W +: W] = m_st[i][c];
            end
            e_cap = (i == 0) ? (~v.le & vp.le) : m_stb[i];
            check($sformatf("model u%0d Q", i),       q_o[i],    e_q);
            check($sformatf("model u%0d Q_INT", i),   qint_o[i], e_qint);
            check($sformatf("model u%0d QEN", i),     {28'h0, qen_o[i]}, {28'h0, ~v.noe});
            check($sformatf("model u%0d CAP_STB", i), {28'h0, cap_o[i]}, {28'h0, e_cap});
         end
      end
   end

   initial begin
      rst  = 1'b1;
      le0  = '1;  le1  = '1;
      d0   = {C{8'hA5}};
      d1   = {C{8'hA5}};
      noe0 = '0;  noe1 = '0;

      // reset held with LE high, D=A5, outputs requested on
      tick(1);
      for (int i = 0; i < 2; i++) begin
         check("rst Q",       q_o[i],    32'h0);
         check("rst QEN",     {28'h0, qen_o[i]}, 32'h0);
         check("rst Q_INT",   qint_o[i], 32'h0);
         check("rst CAP_STB", {28'h0, cap_o[i]}, 32'h0);
      end
      tick(2);
      check("rst hold u0 Q", q_o[0], 32'h0);
      check("rst hold u1 Q", q_o[1], 32'h0);

      // release: u1 keeps LE high through release and must capture once
      rst  = 1'b0;
      le0  = '0;  d0 = '0;  noe0 = '1;
      tick(1);
      for (int i = 0; i < 2; i++) begin
         check("post rst Q",       q_o[i],    32'h0);
         check("post rst QEN",     {28'h0, qen_o[i]}, 32'h0);
         check("post rst Q_INT",   qint_o[i], 32'h0);
         check("post rst CAP_STB", {28'h0, cap_o[i]}, 32'h0);
      end
      tick(2);
      check("le high thru rst Q_INT", qint_o[1], 32'hA5A5A5A5);
      check("le high thru rst CAP",   {28'h0, cap_o[1]}, 32'hF);
      tick(1);
      check("le high thru rst CAP end", {28'h0, cap_o[1]}, 32'h0);
      le1 = '0;  d1 = '0;
      tick(3);

      // transparent latch, ch0
      noe0 = '0;  le0 = 4'b0001;  d0 = 32'h3C;
      tick(3);
      check("m0 Q_INT 3C", qint_o[0], 32'h3C);
      check("m0 Q 3C",     q_o[0],    32'h3C);
      check("m0 QEN",      {28'h0, qen_o[0]}, 32'hF);
      d0 = 32'hC3;
      tick(3);
      check("m0 Q follows C3", q_o[0], 32'hC3);
      le0 = '0;  d0 = 32'hFF;
      tick(1);
      check("m0 fall CAP early", {28'h0, cap_o[0]}, 32'h0);
      tick(1);
      check("m0 fall CAP pulse", {28'h0, cap_o[0]}, 32'h1);
      check("m0 fall Q hold",    q_o[0], 32'hC3);
      tick(1);
      check("m0 fall CAP end",   {28'h0, cap_o[0]}, 32'h0);
      check("m0 Q ignores FF",   q_o[0], 32'hC3);

      // edge register, ch1, LE held high while D steps
      le1 = 4'b0010;  d1 = 32'h0000_1100;
      tick(1);
      d1 = 32'h0000_2200;
      tick(1);
      d1 = 32'h0000_3300;
      tick(1);
      check("m1 first edge Q_INT", qint_o[1], 32'hA5A511A5);
      check("m1 first edge CAP",   {28'h0, cap_o[1]}, 32'h2);
      tick(1);
      check("m1 single CAP",       {28'h0, cap_o[1]}, 32'h0);
      tick(2);
      check("m1 held LE no reload", qint_o[1], 32'hA5A511A5);
      le1 = '0;
      tick(3);
      le1 = 4'b0010;  d1 = 32'h0000_4400;
      tick(3);
      check("m1 second edge Q_INT", qint_o[1], 32'hA5A544A5);
      check("m1 second edge CAP",   {28'h0, cap_o[1]}, 32'h2);
      le1 = '0;
      tick(3);

      // output enable on u0 ch0
      le0 = 4'b0001;  d0 = 32'h5A;
      tick(3);
      le0 = '0;
      tick(3);
      check("oe Q 5A", q_o[0], 32'h5A);
      noe0 = 4'b0001;
      tick(1);
      check("oe off Q still", q_o[0], 32'h5A);
      tick(1);
      check("oe off Q",     q_o[0],    32'h0);
      check("oe off QEN",   {28'h0, qen_o[0]}, 32'hE);
      check("oe off Q_INT", qint_o[0], 32'h5A);
      le0 = 4'b0001;  d0 = 32'h99;
      tick(3);
      le0 = '0;
      tick(3);
      check("oe off load Q_INT", qint_o[0], 32'h99);
      check("oe off load Q",     q_o[0],    32'h0);
      noe0 = '0;
      tick(1);
      check("oe on Q still 0", q_o[0], 32'h0);
      tick(1);
      check("oe on Q 99", q_o[0], 32'h99);
      check("oe on QEN",  {28'h0, qen_o[0]}, 32'hF);

      // simultaneous edges on ch0 and ch3 of u1
      le1 = 4'b1001;  d1 = 32'h08FF_FF01;
      tick(3);
      check("indep Q_INT", qint_o[1], 32'h08A54401);
      check("indep CAP",   {28'h0, cap_o[1]}, 32'h9);
      tick(1);
      check("indep CAP end", {28'h0, cap_o[1]}, 32'h0);
      le1 = '0;
      tick(3);

      // reset lands on the capture edge
      le1 = 4'b0100;  d1 = 32'h0077_0000;
      tick(2);
      rst = 1'b1;  le1 = '0;
      tick(1);
      check("rst on cap Q_INT", qint_o[1], 32'h0);
      check("rst on cap CAP",   {28'h0, cap_o[1]}, 32'h0);
      check("rst on cap Q",     q_o[1],    32'h0);
      check("rst on cap u0",    qint_o[0], 32'h0);
      rst = 1'b0;
      tick(3);
      check("after rst Q_INT", qint_o[1], 32'h0);
      check("after rst CAP",   {28'h0, cap_o[1]}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
